// File: rtl/register_file_pkg.sv
// Shared register-file types and dimensions, imported by decode, write-back
// and the register file itself.
package register_file_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

  typedef logic [RF_DATA_W-1:0] word_t;
  typedef logic [RF_ADDR_W-1:0] reg_idx_t;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// 16 x 32 general-purpose register file: two combinational read ports and one
// write port that commits on the falling clock edge.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeBackEn,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [ADDR_W-1:0] Dest_wb,
  input  logic [DATA_W-1:0] Result_WB,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Committing on the falling edge lets decode see a write-back result in the
  // same cycle, giving write-first behaviour at the next rising edge.
  // NOTE: every entry is reset explicitly; this array must clear asynchronously,
  // so it cannot map onto a RAM macro and is built from flops.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeBackEn) begin
      // NOTE: non-blocking assignment keeps storage updates ordered against
      // every other clocked process sampling on this edge.
      regs[Dest_wb] <= Result_WB;
    end
  end

  // Pure read multiplexers; reset drives every entry to zero, so the outputs
  // read zero while rst is low without extra gating.
  assign reg1 = regs[src1];
  assign reg2 = regs[src2];

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized
// phase checked against an array model of the register contents.
module tb_register_file;
  import register_file_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     writeBackEn;
  reg_idx_t src1, src2, Dest_wb;
  word_t    Result_WB;
  word_t    reg1, reg2;

  int tests = 0;
  int fails = 0;

  word_t model [RF_NUM_REGS];

  register_file dut (
    .clk        (clk),
    .rst        (rst),
    .writeBackEn(writeBackEn),
    .src1       (src1),
    .src2       (src2),
    .Dest_wb    (Dest_wb),
    .Result_WB  (Result_WB),
    .reg1       (reg1),
    .reg2       (reg2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input reg_idx_t a, input reg_idx_t b);
    src1 = a;
    src2 = b;
    #1;
    check({tag, " reg1"}, reg1, model[a]);
    check({tag, " reg2"}, reg2, model[b]);
  endtask

  // Drive a write just after a rising edge, commit it in the model at the
  // falling edge that follows, then drop the enable.
  task automatic do_write(input reg_idx_t dest, input word_t data);
    @(posedge clk);
    #1;
    writeBackEn = 1'b1;
    Dest_wb     = dest;
    Result_WB   = data;
    @(negedge clk);
    model[dest] = data;
    #1;
    writeBackEn = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < RF_NUM_REGS; i++) model[i] = '0;
  endtask

  initial begin
    rst         = 1'b0;
    writeBackEn = 1'b0;
    src1        = '0;
    src2        = '0;
    Dest_wb     = '0;
    Result_WB   = '0;
    clear_model();

    // Reset held 100 ns, then released between edges.
    #60;
    read_chk("in_reset", 4'd3, 4'd12);
    #42;
    rst = 1'b1;
    for (int i = 0; i < RF_NUM_REGS; i++) read_chk("reset_all", reg_idx_t'(i), reg_idx_t'(i));

    // Single write, other registers untouched.
    do_write(4'd5, 32'd6);
    read_chk("single_write", 4'd0, 4'd5);
    for (int i = 0; i < RF_NUM_REGS; i++) read_chk("others_zero", reg_idx_t'(i), 4'd5);

    // Second write and dual read, stable for 100 us.
    do_write(4'd6, 32'd7);
    src1 = 4'd6;
    src2 = 4'd5;
    for (int i = 0; i < 100; i++) begin
      #1000;
      check("stable reg1", reg1, 32'd7);
      check("stable reg2", reg2, 32'd6);
    end

    // Write disabled: nothing changes.
    @(posedge clk);
    #1;
    writeBackEn = 1'b0;
    Dest_wb     = 4'd5;
    Result_WB   = 32'hDEADBEEF;
    repeat (4) @(negedge clk);
    #1;
    read_chk("wr_disabled", 4'd5, 4'd5);

    // Same-cycle write/read of R9: old value before the falling edge, new after.
    @(posedge clk);
    #1;
    src1        = 4'd9;
    writeBackEn = 1'b1;
    Dest_wb     = 4'd9;
    Result_WB   = 32'hA5A5A5A5;
    #1;
    check("same_cycle_old", reg1, 32'h0);
    @(negedge clk);
    #1;
    check("same_cycle_new", reg1, 32'hA5A5A5A5);
    writeBackEn = 1'b0;
    model[9]    = 32'hA5A5A5A5;

    // Back-to-back writes to one index: last wins.
    do_write(4'd7, 32'h1111_2222);
    do_write(4'd7, 32'h3333_4444);
    read_chk("last_wins", 4'd7, 4'd7);

    // Async reset mid-cycle overrides a pending write.
    do_write(4'd15, 32'hFFFFFFFF);
    read_chk("r15_written", 4'd15, 4'd3);
    @(posedge clk);
    #1;
    writeBackEn = 1'b1;
    Dest_wb     = 4'd3;
    Result_WB   = 32'h0BAD_F00D;
    #1;
    rst = 1'b0;
    clear_model();
    #1;
    check("async_rst r15", reg1, 32'h0);
    @(negedge clk);
    #1;
    check("rst_blocks_write", reg2, 32'h0);
    #2;
    rst = 1'b1;
    writeBackEn = 1'b0;
    read_chk("after_rst", 4'd15, 4'd9);
    do_write(4'd3, 32'hCAFE_0003);
    read_chk("first_write_after_rst", 4'd3, 4'd15);

    // Randomized traffic: every cycle check old value before and new value
    // after the falling edge.
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      writeBackEn = 1'($urandom_range(0, 1));
      Dest_wb     = reg_idx_t'($urandom_range(0, RF_NUM_REGS - 1));
      Result_WB   = word_t'($urandom);
      src1        = (n % 4 == 0) ? Dest_wb : reg_idx_t'($urandom_range(0, RF_NUM_REGS - 1));
      src2        = reg_idx_t'($urandom_range(0, RF_NUM_REGS - 1));
      #1;
      check("rand_pre reg1", reg1, model[src1]);
      check("rand_pre reg2", reg2, model[src2]);
      @(negedge clk);
      if (writeBackEn) model[Dest_wb] = Result_WB;
      #1;
      check("rand_post reg1", reg1, model[src1]);
      check("rand_post reg2", reg2, model[src2]);
    end
    writeBackEn = 1'b0;
    for (int i = 0; i < RF_NUM_REGS; i++) read_chk("final_sweep", reg_idx_t'(i), reg_idx_t'(RF_NUM_REGS - 1 - i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_register_file
